// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves hps_io upload reads from a sync-read RAM port.
// It holds the CPU off the bus for the whole session and fetches one byte per ioctl_rd.
// Ports: clk_sys, reset (async, active-high).
// hps_io side: ioctl_upload/ioctl_rd/ioctl_addr in, ioctl_din/ioctl_wait out.
// CPU side: bus_req out, bus_gnt in. RAM side: mem_addr/mem_rd out, mem_q in.
// Checksum: upload_csum out, active only when UPLOAD_CSUM_EN is defined (tied to 0 otherwise).
module ioctl_upload_reader #(
  parameter int         ADDR_W = 12,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] FILL   = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [26:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic [15:0]       upload_csum
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_READY, S_FETCH, S_HOLD
  } state_t;

  state_t            state_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              req_q;
  logic [ADDR_W-1:0] maddr_q;
  logic              mrd_q;
  logic [1:0]        cnt_q;
  logic              pend_q;
  logic [26:0]       paddr_q;

  logic        svc;
  logic [26:0] svc_addr;
  logic        in_range;

  // A latched read (from ARB or an aborted fetch) takes priority.
  // A fresh strobe counts only when no read is outstanding.
  assign svc      = pend_q | (ioctl_rd & ~wait_q);
  assign svc_addr = pend_q ? paddr_q : ioctl_addr;
  assign in_range = ~|svc_addr[26:ADDR_W];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      din_q   <= '0;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      mrd_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
    end else begin
      mrd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Level test, so a re-raise during HOLD is honoured here.
          if (ioctl_upload) begin
            req_q   <= 1'b1;
            wait_q  <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= S_ARB;
          end
        end
        S_HOLD: state_q <= S_IDLE;
        default: begin
          if (!ioctl_upload) begin
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= S_HOLD;
          end else if (state_q == S_ARB) begin
            if (ioctl_rd && !pend_q) begin
              pend_q  <= 1'b1;
              paddr_q <= ioctl_addr;
            end
            if (bus_gnt) begin
              wait_q  <= pend_q | ioctl_rd;
              state_q <= S_READY;
            end
          end else if (!bus_gnt) begin
            // Grant lost: park and replay the read after regrant.
            wait_q  <= 1'b1;
            state_q <= S_ARB;
            if (state_q == S_FETCH) begin
              pend_q <= 1'b1;
            end else if (ioctl_rd && !wait_q) begin
              pend_q  <= 1'b1;
              paddr_q <= ioctl_addr;
            end
          end else if (state_q == S_READY) begin
            if (svc) begin
              pend_q  <= 1'b0;
              paddr_q <= svc_addr;
              if (in_range) begin
                maddr_q <= svc_addr[ADDR_W-1:0];
                mrd_q   <= 1'b1;
                wait_q  <= 1'b1;
                cnt_q   <= 2'(RD_LAT);
                state_q <= S_FETCH;
              end else begin
                din_q  <= FILL;
                wait_q <= 1'b0;
              end
            end
          end else begin
            if (cnt_q == 2'd0) begin
              din_q   <= mem_q;
              wait_q  <= 1'b0;
              state_q <= S_READY;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign bus_req    = req_q;
  assign mem_addr   = maddr_q;
  assign mem_rd     = mrd_q;

`ifdef UPLOAD_CSUM_EN
  logic [15:0] csum_q;
  logic        start_ev;
  logic        fill_ev;
  logic        ram_ev;

  // These mirror the FSM branches that write ioctl_din.
  assign start_ev = (state_q == S_IDLE) & ioctl_upload;
  assign fill_ev  = ioctl_upload & bus_gnt & (state_q == S_READY)
                  & svc & ~in_range;
  assign ram_ev   = ioctl_upload & bus_gnt & (state_q == S_FETCH)
                  & (cnt_q == 2'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (start_ev) begin
      csum_q <= '0;
    end else if (fill_ev) begin
      csum_q <= csum_q + {8'h00, FILL};
    end else if (ram_ev) begin
      csum_q <= csum_q + {8'h00, mem_q};
    end
  end

  assign upload_csum = csum_q;
`else
  assign upload_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed testbench for ioctl_upload_reader (ADDR_W=12, RD_LAT=1).
// It uses a behavioural 1-clock sync RAM, and all expected values are hand-computed.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        bus_req;
  logic        bus_gnt;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic [15:0] upload_csum;

  logic [7:0]  ram [4096];
  logic [7:0]  exp6 [4];
  int          errs = 0;
  int          checks = 0;

  ioctl_upload_reader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_q        (mem_q),
    .upload_csum  (upload_csum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (mem_rd) mem_q <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (ioctl_wait && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic rd(input logic [26:0] a);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i ^ 8'h3C);
    ram[12'h010] = 8'hA5;
    ram[12'h020] = 8'h5A;
    ram[12'h000] = 8'h01;
    ram[12'h001] = 8'h02;
    ram[12'h002] = 8'h03;
    ram[12'h003] = 8'hFF;
    exp6[0] = 8'h01;
    exp6[1] = 8'h02;
    exp6[2] = 8'h03;
    exp6[3] = 8'hFF;
    mem_q        = 8'h00;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    bus_gnt      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_din", {24'd0, ioctl_din}, 32'h0);
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_mrd", {31'd0, mem_rd}, 32'd0);
    check("rst_csum", {16'd0, upload_csum}, 32'h0);

    // T1: request one clock after rise, wait held until grant
    ioctl_upload = 1'b1;
    tick();
    check("t1_req", {31'd0, bus_req}, 32'd1);
    check("t1_wait", {31'd0, ioctl_wait}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("t1_wait_nogt", {31'd0, ioctl_wait}, 32'd1);
    bus_gnt = 1'b1;
    tick();
    check("t1_wait_gnt", {31'd0, ioctl_wait}, 32'd0);
    check("t1_req_hold", {31'd0, bus_req}, 32'd1);

    // T2: in-range fetch, RD_LAT=1
    rd(27'h010);
    check("t2_mrd", {31'd0, mem_rd}, 32'd1);
    check("t2_maddr", {20'd0, mem_addr}, 32'h010);
    check("t2_wait", {31'd0, ioctl_wait}, 32'd1);
    tick();
    check("t2_mrd_off", {31'd0, mem_rd}, 32'd0);
    check("t2_wait2", {31'd0, ioctl_wait}, 32'd1);
    tick();
    check("t2_din", {24'd0, ioctl_din}, 32'hA5);
    check("t2_wait_lo", {31'd0, ioctl_wait}, 32'd0);

    // T3: out-of-range returns FILL with no RAM access
    rd(27'h1000);
    check("t3_din", {24'd0, ioctl_din}, 32'hFF);
    check("t3_wait", {31'd0, ioctl_wait}, 32'd0);
    check("t3_mrd", {31'd0, mem_rd}, 32'd0);
    tick();
    check("t3_mrd2", {31'd0, mem_rd}, 32'd0);

    // T4: grant lost mid-fetch, read replayed after regrant
    rd(27'h020);
    bus_gnt = 1'b0;
    tick();
    check("t4_wait", {31'd0, ioctl_wait}, 32'd1);
    tick();
    tick();
    check("t4_wait2", {31'd0, ioctl_wait}, 32'd1);
    check("t4_din_old", {24'd0, ioctl_din}, 32'hFF);
    check("t4_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    tick();
    wait_done("t4_timeout");
    check("t4_din", {24'd0, ioctl_din}, 32'h5A);

    // T5: upload ends mid-fetch, then reset mid-upload
    rd(27'h010);
    ioctl_upload = 1'b0;
    tick();
    check("t5_req", {31'd0, bus_req}, 32'd0);
    check("t5_wait", {31'd0, ioctl_wait}, 32'd0);
    check("t5_din_keep", {24'd0, ioctl_din}, 32'h5A);
    tick();
    tick();
    check("t5_idle_req", {31'd0, bus_req}, 32'd0);
    ioctl_upload = 1'b1;
    tick();
    check("t5_req_again", {31'd0, bus_req}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("t5_rst_req", {31'd0, bus_req}, 32'd0);
    check("t5_rst_din", {24'd0, ioctl_din}, 32'h0);
    check("t5_rst_wait", {31'd0, ioctl_wait}, 32'd0);
    ioctl_upload = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // T6: four bytes, checksum 01+02+03+FF = 0x0105
    ioctl_upload = 1'b1;
    tick();
    tick();
    check("t6_ready", {31'd0, ioctl_wait}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(27'(i));
      wait_done("t6_timeout");
      check("t6_din", {24'd0, ioctl_din}, {24'd0, exp6[i]});
    end
`ifdef UPLOAD_CSUM_EN
    check("t6_csum", {16'd0, upload_csum}, 32'h0105);
    ioctl_upload = 1'b0;
    tick();
    tick();
    tick();
    check("t6_csum_frz", {16'd0, upload_csum}, 32'h0105);
`else
    check("t6_csum_off", {16'd0, upload_csum}, 32'h0);
    ioctl_upload = 1'b0;
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
